// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
// Provides the queue entry layout, the NOP encoding, the PC step and a count-width helper.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Bits needed to hold a count in 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head word read straight from storage.
// Ports: clk, reset (sync, active-low), push/pop/flush, din/dout, full, empty, count.
module fetch_fifo import fetch_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Flush wins over both push and pop in the same cycle.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order fetch front end feeding IF/ID from a pipelined imem.
// Ports: clk, reset (sync, active-low), imem_req_*, imem_rsp_*, redirect_*,
// IF_ID_Write, head PC/Instruction/inst_valid, occupancy.
module if_fetch_queue import fetch_pkg::*; #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       IF_ID_Write,
    output logic [31:0]                PC,
    output logic [31:0]                Instruction,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = cnt_w(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] out_next;
    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          rsp_ok;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic          tag_full;
    logic          tag_empty;
    logic [31:0]   tag_dout;
    fetch_entry_t  q_din;
    fetch_entry_t  q_dout;

    // Queued plus in-flight words never exceed DEPTH, so a response
    // always has a slot waiting for it.
    assign credit_sum = (CW+1)'(q_count) + (CW+1)'(outstanding);

    assign imem_req_valid = reset && !redirect_valid && !tag_full
                            && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale words still pop their tag so tags stay aligned with responses.
    assign rsp_ok = imem_rsp_valid && (outstanding != '0);
    assign q_push = rsp_ok && (drop == '0) && !redirect_valid;
    assign q_pop  = inst_valid && IF_ID_Write && !redirect_valid;

    assign q_din.pc    = tag_dout;
    assign q_din.instr = imem_rsp_data;

    assign inst_valid  = !q_empty;
    assign PC          = q_empty ? fetch_pc : q_dout.pc;
    assign Instruction = q_empty ? NOP_INSTR : q_dout.instr;
    assign occupancy   = q_count;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (rsp_ok),
        .flush (1'b0),
        .din   (fetch_pc),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    always_comb begin
        out_next = outstanding;
        if (req_fire) begin
            out_next = out_next + CW'(1);
        end
        if (rsp_ok) begin
            out_next = out_next - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight now belongs to the old path.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= out_next;
            drop        <= out_next;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            outstanding <= out_next;
            if (rsp_ok && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!imem_rsp_valid || (outstanding != '0));
            assert (tag_empty == (tag_count == '0));
            assert (tag_count == outstanding);
            assert (!(q_push && q_full && !q_pop));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized bench with an imem model and an in-order scoreboard.
// Expected PC streams are pushed per fetch epoch; monitors compare on handshakes.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          IF_ID_Write;
    logic [31:0]   PC;
    logic [31:0]   Instruction;
    logic          inst_valid;
    logic [CW-1:0] occupancy;

    if_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IF_ID_Write    (IF_ID_Write),
        .PC             (PC),
        .Instruction    (Instruction),
        .inst_valid     (inst_valid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_exp;
    logic [31:0] req_exp;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          errors;
    int          checks;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_exp);
            next_exp += 32'd4;
        end
    endtask

    // A new fetch path: the head stream and request stream restart here.
    task automatic new_epoch(input logic [31:0] target);
        exp_q.delete();
        next_exp = target;
        req_exp  = target;
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        top_up();
    endtask

    // Memory model: records accepted requests and checks address order.
    initial begin : mem_model
        int    due;
        mreq_t m;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_q.delete();
                last_due = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, req_exp);
                req_exp += 32'd4;
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) begin
                    due = last_due + 1;
                end
                m.due  = due;
                m.addr = imem_req_addr;
                mem_q.push_back(m);
                last_due = due;
            end
        end
    end

    // Head monitor: the presented head must always be the scoreboard front.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset && !redirect_valid) begin
                if (inst_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL head_underflow: got pc %h expected none", PC);
                    end else begin
                        check("head_pc", PC, exp_q[0]);
                        check("head_instr", Instruction, inst_of(exp_q[0]));
                        if (IF_ID_Write) begin
                            void'(exp_q.pop_front());
                        end
                    end
                end else begin
                    check("empty_nop", Instruction, 32'h0);
                end
            end
        end
    end

    initial begin
        int n;
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        last_due       = 0;
        lat_min        = 1;
        lat_max        = 1;
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        IF_ID_Write    = 1'b0;
        new_epoch(RESET_PC);

        repeat (2) tick();
        @(negedge clk);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc", PC, RESET_PC);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Release with L=1 and no stalls.
        tick();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        IF_ID_Write    = 1'b1;
        @(negedge clk);
        check("c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("c1_req_addr", imem_req_addr, RESET_PC);
        check("c1_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c2_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c3_inst_valid", 32'(inst_valid), 32'd1);
        check("c3_pc", PC, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(inst_valid), 32'd1);
        end

        // Stall until credits run out.
        tick();
        IF_ID_Write = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("stall_occupancy", 32'(occupancy), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);

        // Reset with the queue full.
        tick();
        reset = 1'b0;
        new_epoch(RESET_PC);
        tick();
        reset       = 1'b1;
        IF_ID_Write = 1'b1;
        @(negedge clk);
        check("mrst_inst_valid", 32'(inst_valid), 32'd0);
        check("mrst_instr", Instruction, 32'h0);
        check("mrst_occupancy", 32'(occupancy), 32'd0);
        check("mrst_req_valid", 32'(imem_req_valid), 32'd1);
        check("mrst_req_addr", imem_req_addr, RESET_PC);

        // Redirect with several requests in flight at L=3.
        tick();
        lat_min = 3;
        lat_max = 3;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        new_epoch(32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_occupancy", 32'(occupancy), 32'd0);
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("t3_valid", 32'(inst_valid), 32'd1);
        check("t3_first_pc", PC, 32'h100);

        // Redirect colliding with a response and a pop, unaligned target.
        tick();
        lat_min = 1;
        lat_max = 1;
        repeat (8) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        new_epoch(32'h100);
        @(negedge clk);
        check("t4_head_valid", 32'(inst_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_occupancy", 32'(occupancy), 32'd0);
        check("t4_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h100);

        // Memory backpressure: request must hold.
        repeat (6) tick();
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_valid", 32'(imem_req_valid), 32'd1);
            check("bp_req_addr", imem_req_addr, req_exp);
            tick();
        end
        imem_req_ready = 1'b1;

        // Random traffic.
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 1500; i++) begin
            tick();
            reset          = 1'b1;
            redirect_valid = 1'b0;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            IF_ID_Write    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                new_epoch(RESET_PC);
            end else if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom();
                new_epoch({redirect_pc[31:2], 2'b00});
            end
        end
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        IF_ID_Write    = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("final_valid", 32'(inst_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
